// File: rtl/hex_segment_reader.sv
// Seven-segment readback monitor: debounces the active-low segment bus and decodes each
// digit back to a hex nibble, flagging blank and illegal patterns.
module hex_segment_reader #(
    parameter int unsigned NUM_DIGITS    = 6,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [7*NUM_DIGITS-1:0] seg_in,
    output logic [4*NUM_DIGITS-1:0] value,
    output logic [NUM_DIGITS-1:0]   blank,
    output logic [NUM_DIGITS-1:0]   err,
    output logic                    update,
    output logic                    stable,
    output logic [15:0]             update_count
);

    localparam logic [7:0] StableMax = 8'(STABLE_CYCLES);

    logic [7*NUM_DIGITS-1:0] samp;
    logic [7:0]              cnt;
    logic                    first;

    logic [4*NUM_DIGITS-1:0] dec_value;
    logic [NUM_DIGITS-1:0]   dec_blank;
    logic [NUM_DIGITS-1:0]   dec_err;
    logic [5:0]              dec_digit;
    logic                    same;
    logic                    capture;
    logic                    changed;

    // Returns {err, blank, nibble}; blank and illegal codes both decode to nibble 0.
    function automatic logic [5:0] decode(input logic [6:0] code);
        logic [5:0] r;
        r = 6'b000000;
        case (code)
            7'h40: r[3:0] = 4'h0;
            7'h79: r[3:0] = 4'h1;
            7'h24: r[3:0] = 4'h2;
            7'h30: r[3:0] = 4'h3;
            7'h19: r[3:0] = 4'h4;
            7'h12: r[3:0] = 4'h5;
            7'h02: r[3:0] = 4'h6;
            7'h78: r[3:0] = 4'h7;
            7'h00: r[3:0] = 4'h8;
            7'h18: r[3:0] = 4'h9;
            7'h08: r[3:0] = 4'hA;
            7'h03: r[3:0] = 4'hB;
            7'h46: r[3:0] = 4'hC;
            7'h21: r[3:0] = 4'hD;
            7'h06: r[3:0] = 4'hE;
            7'h0E: r[3:0] = 4'hF;
            7'h7F: r[4]   = 1'b1;
            default: r[5] = 1'b1;
        endcase
        return r;
    endfunction

    always_comb begin
        dec_value = '0;
        dec_blank = '0;
        dec_err   = '0;
        dec_digit = '0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            dec_digit            = decode(samp[7*i +: 7]);
            dec_value[4*i +: 4]  = dec_digit[3:0];
            dec_blank[i]         = dec_digit[4];
            dec_err[i]           = dec_digit[5];
        end
    end

    always_comb begin
        same    = (seg_in == samp);
        capture = same && (cnt == StableMax - 8'd1);
        changed = first || ({dec_value, dec_blank, dec_err} != {value, blank, err});
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            samp         <= {NUM_DIGITS{7'h7F}};
            cnt          <= 8'd0;
            first        <= 1'b1;
            value        <= '0;
            blank        <= '1;
            err          <= '0;
            update       <= 1'b0;
            stable       <= 1'b0;
            update_count <= 16'd0;
        end else begin
            update <= 1'b0;
            if (!same) begin
                samp   <= seg_in;
                cnt    <= 8'd0;
                stable <= 1'b0;
            end else if (cnt != StableMax) begin
                cnt    <= cnt + 8'd1;
                stable <= (cnt + 8'd1 == StableMax);
            end else begin
                stable <= 1'b1;
            end
            // A pattern identical to the held one (e.g. after a glitch) is not re-reported.
            if (capture && changed) begin
                value        <= dec_value;
                blank        <= dec_blank;
                err          <= dec_err;
                update       <= 1'b1;
                update_count <= update_count + 16'd1;
                first        <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hex_segment_reader.sv
// Directed bench for hex_segment_reader with default parameters (6 digits, 4 stable cycles).
module tb_hex_segment_reader;

    localparam logic [34:0] Blank5 = {5{7'h7F}};

    logic        clock;
    logic        reset;
    logic [41:0] seg_in;
    logic [23:0] value;
    logic [5:0]  blank;
    logic [5:0]  err;
    logic        update;
    logic        stable;
    logic [15:0] update_count;

    int pass_cnt;
    int total_cnt;

    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    hex_segment_reader #(
        .NUM_DIGITS    (6),
        .STABLE_CYCLES (4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .seg_in       (seg_in),
        .value        (value),
        .blank        (blank),
        .err          (err),
        .update       (update),
        .stable       (stable),
        .update_count (update_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input logic [41:0] seg);
        reset  = 1'b1;
        seg_in = seg;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset({6{7'h7F}});
        reset = 1'b1;
        tick();
        total_cnt++;
        if (value !== 24'h0) $display("FAIL reset_value got %h want %h", value, 24'h0);
        else pass_cnt++;
        total_cnt++;
        if (blank !== 6'h3F) $display("FAIL reset_blank got %b want %b", blank, 6'h3F);
        else pass_cnt++;
        total_cnt++;
        if (err !== 6'h00) $display("FAIL reset_err got %b want %b", err, 6'h00);
        else pass_cnt++;
        total_cnt++;
        if ({update, stable} !== 2'b00)
            $display("FAIL reset_update_stable got %b want 00", {update, stable});
        else pass_cnt++;
        total_cnt++;
        if (update_count !== 16'd0) $display("FAIL reset_count got %0d want 0", update_count);
        else pass_cnt++;
    endtask

    task automatic test_single_digit();
        do_reset({Blank5, 7'h24});
        for (int i = 1; i <= 6; i++) begin
            tick();
            total_cnt++;
            if (update !== (i == 5))
                $display("FAIL single_update_edge%0d got %b want %b", i, update, (i == 5));
            else pass_cnt++;
        end
        total_cnt++;
        if (value[3:0] !== 4'h2) $display("FAIL single_value got %h want 2", value[3:0]);
        else pass_cnt++;
        total_cnt++;
        if (blank !== 6'b111110) $display("FAIL single_blank got %b want 111110", blank);
        else pass_cnt++;
        total_cnt++;
        if (update_count !== 16'd1) $display("FAIL single_count got %0d want 1", update_count);
        else pass_cnt++;
        total_cnt++;
        if (stable !== 1'b1) $display("FAIL single_stable got %b want 1", stable);
        else pass_cnt++;
    endtask

    task automatic test_glyph_sweep();
        int ups;
        do_reset({Blank5, glyph[0]});
        for (int g = 0; g < 16; g++) begin
            seg_in = {Blank5, glyph[g]};
            ups = 0;
            for (int c = 0; c < 8; c++) begin
                tick();
                if (update === 1'b1) ups++;
            end
            total_cnt++;
            if (ups != 1 || value[3:0] !== 4'(g) || err !== 6'h0 || blank !== 6'b111110)
                $display("FAIL sweep_glyph%0d ups=%0d val=%h err=%b blank=%b want 1 %h 0 111110",
                         g, ups, value[3:0], err, blank, 4'(g));
            else pass_cnt++;
        end
        total_cnt++;
        if (update_count !== 16'd16) $display("FAIL sweep_count got %0d want 16", update_count);
        else pass_cnt++;
    endtask

    task automatic test_illegal();
        int ups;
        seg_in = {Blank5, 7'h40};
        repeat (8) tick();
        seg_in = {{4{7'h7F}}, 7'h7E, 7'h40};
        ups = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (update === 1'b1) ups++;
        end
        total_cnt++;
        if (ups != 1 || err !== 6'b000010 || value[7:4] !== 4'h0 || blank !== 6'b111100)
            $display("FAIL illegal_code ups=%0d err=%b val=%h blank=%b want 1 000010 0 111100",
                     ups, err, value[7:4], blank);
        else pass_cnt++;
        seg_in = {{4{7'h7F}}, 7'h79, 7'h40};
        repeat (8) tick();
        total_cnt++;
        if (err !== 6'b000000 || value[7:0] !== 8'h10)
            $display("FAIL illegal_recover err=%b val=%h want 000000 10", err, value[7:0]);
        else pass_cnt++;
    endtask

    task automatic test_glitch();
        int ups;
        logic [15:0] cnt_before;
        seg_in = {Blank5, 7'h30};
        repeat (8) tick();
        cnt_before = update_count;
        total_cnt++;
        if (value[3:0] !== 4'h3) $display("FAIL glitch_pre_value got %h want 3", value[3:0]);
        else pass_cnt++;
        seg_in = {Blank5, 7'h12};
        tick();
        total_cnt++;
        if (stable !== 1'b0) $display("FAIL glitch_stable_drop got %b want 0", stable);
        else pass_cnt++;
        ups = (update === 1'b1) ? 1 : 0;
        repeat (2) begin
            tick();
            if (update === 1'b1) ups++;
        end
        seg_in = {Blank5, 7'h30};
        for (int c = 0; c < 10; c++) begin
            tick();
            if (update === 1'b1) ups++;
        end
        total_cnt++;
        if (ups != 0 || value[3:0] !== 4'h3)
            $display("FAIL glitch_reject ups=%0d val=%h want 0 3", ups, value[3:0]);
        else pass_cnt++;
        total_cnt++;
        if (stable !== 1'b1 || update_count !== cnt_before)
            $display("FAIL glitch_restable stable=%b count=%0d want 1 %0d",
                     stable, update_count, cnt_before);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_count();
        seg_in = {Blank5, 7'h02};
        tick();
        tick();
        reset = 1'b1;
        tick();
        total_cnt++;
        if (value !== 24'h0 || blank !== 6'h3F || err !== 6'h0 || update !== 1'b0 ||
            stable !== 1'b0 || update_count !== 16'd0)
            $display("FAIL midreset_outputs val=%h blank=%b err=%b upd=%b stb=%b cnt=%0d",
                     value, blank, err, update, stable, update_count);
        else pass_cnt++;
        reset = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            total_cnt++;
            if (update !== (i == 5))
                $display("FAIL midreset_update_edge%0d got %b want %b", i, update, (i == 5));
            else pass_cnt++;
        end
        total_cnt++;
        if (value[3:0] !== 4'h6 || update_count !== 16'd1)
            $display("FAIL midreset_value val=%h cnt=%0d want 6 1", value[3:0], update_count);
        else pass_cnt++;
    endtask

    task automatic test_counter_wrap();
        logic [15:0] want [3] = '{16'hFFFF, 16'h0000, 16'h0001};
        // Preload the counter near its top; a real 65536-update run is far too long.
        force dut.update_count = 16'hFFFE;
        tick();
        release dut.update_count;
        for (int k = 0; k < 3; k++) begin
            seg_in = {Blank5, (k % 2 == 0) ? 7'h40 : 7'h79};
            repeat (6) tick();
            total_cnt++;
            if (update_count !== want[k])
                $display("FAIL wrap_step%0d got %h want %h", k, update_count, want[k]);
            else pass_cnt++;
        end
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        reset     = 1'b1;
        seg_in    = {6{7'h7F}};
        test_reset();
        test_single_digit();
        test_glyph_sweep();
        test_illegal();
        test_glitch();
        test_reset_mid_count();
        test_counter_wrap();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
